gf2m_reduce_193bit: RTL and testbench

//  Reduces the 385-bit polynomial product of OKA_193bit modulo the GF(2^193) trinomial
//  f(x) = x^N + x^K + 1 (default x^193 + x^15 + 1). Sits directly downstream of the

---
 rtl/gf2m_reduce_193bit.sv | 81 ++++++++
 tb/tb_gf2m_reduce_193bit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_reduce_193bit.sv
// Modular reduction of a 2N-1 bit GF(2) polynomial product by the trinomial x^N + x^K + 1.
// Two registered fold steps; one result held behind a valid/ready handshake.
module gf2m_reduce_193bit #(
  parameter int N = 193,
  parameter int K = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_c,
  output logic           busy
);

  localparam int AW = 2*N - 1;

  typedef enum logic [1:0] {S_IDLE, S_FOLD1, S_FOLD2, S_OUT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc;
  logic          accept;

  // x^(N+i) = x^(K+i) + x^i: folds the upper N-1 coefficients down to degree <= N+K-2
  function automatic logic [AW-1:0] fold1(input logic [AW-1:0] a);
    logic [N-2:0]  hi;
    logic [AW-1:0] r;
    hi               = a[AW-1:N];
    r                = '0;
    r[N-1:0]         = a[N-1:0];
    r[N+K-2:0]       = r[N+K-2:0] ^ {hi, {K{1'b0}}};
    r[N-2:0]         = r[N-2:0] ^ hi;
    return r;
  endfunction

  // Second fold leaves degree <= 2K-2 < N, so no third pass is needed
  function automatic logic [N-1:0] fold2(input logic [N+K-2:0] a);
    logic [K-2:0] h2;
    logic [N-1:0] r;
    h2          = a[N+K-2:N];
    r           = a[N-1:0];
    r[2*K-2:0]  = r[2*K-2:0] ^ {h2, {K{1'b0}}};
    r[K-2:0]    = r[K-2:0] ^ h2;
    return r;
  endfunction

  assign in_ready  = (state == S_IDLE) || ((state == S_OUT) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FOLD1;
      S_FOLD1: state_nxt = S_FOLD2;
      S_FOLD2: state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = accept ? S_FOLD1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      out_c <= '0;
    end else begin
      if (accept)                acc <= in_prod;
      else if (state == S_FOLD1) acc <= fold1(acc);
      if (state == S_FOLD2)      out_c <= fold2(acc[N+K-2:0]);
    end
  end

endmodule

// File: tb/tb_gf2m_reduce_193bit.sv
// Scoreboard bench for gf2m_reduce_193bit: directed products, backpressure and mid-flight reset.
module tb_gf2m_reduce_193bit;

  localparam int N  = 193;
  localparam int K  = 15;
  localparam int AW = 2*N - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_c;
  logic          busy;

  gf2m_reduce_193bit #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] exp;
    bit           lat;
    int           cyc;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: clear the top set bit one at a time using x^i = x^(i-N+K) + x^(i-N)
  function automatic logic [N-1:0] ref_reduce(input logic [AW-1:0] p);
    for (int i = AW-1; i >= N; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i-N+K]   = ~p[i-N+K];
        p[i-N]     = ~p[i-N];
      end
    end
    return p[N-1:0];
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one product; returns the number of extra cycles waited for in_ready
  task automatic send(input logic [AW-1:0] v, input logic [N-1:0] exp, input bit lat,
                      input logic rdy, output int waited);
    sb_t e;
    waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_prod   = v;
    out_ready = rdy;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      e.exp = exp;
      e.lat = lat;
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", N'(q.size()), '0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare on every output handshake
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: out_valid=1 with no pending product, out_c=%h", out_c);
        end else begin
          e = q.pop_front();
          chk("out_c", out_c, e.exp);
          if (e.lat) chk("latency", N'(cyc - e.cyc), N'(3));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] v;
    logic [N-1:0]  e;
    logic [N-1:0]  held;
    int            w;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", N'(out_valid), '0);
    chk("rst_out_c", out_c, '0);
    chk("rst_busy", N'(busy), '0);
    chk("rst_in_ready", N'(in_ready), N'(1));
    rst_n = 1'b1;

    // x^193 -> x^15 + 1
    v = '0; v[193] = 1'b1;
    send(v, N'(16'h8001), 1'b1, 1'b1, w);
    drain();

    // x^384 -> x^191 + x^28 + x^13
    v = '0; v[384] = 1'b1;
    e = '0; e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
    send(v, e, 1'b1, 1'b1, w);
    drain();

    // Already reduced inputs pass through unchanged
    v = '0; v[192:0] = {1'b1, {12{16'hdead}}};
    send(v, v[192:0], 1'b1, 1'b1, w);
    v = '0; v[192:0] = {1'b0, {48{4'h5}}};
    send(v, v[192:0], 1'b1, 1'b1, w);
    drain();

    // x^207 -> x^29 + x^14; x^193 + x^384 combined
    v = '0; v[207] = 1'b1;
    e = '0; e[29] = 1'b1; e[14] = 1'b1;
    send(v, e, 1'b1, 1'b1, w);
    v = '0; v[193] = 1'b1; v[384] = 1'b1;
    e = N'(16'h8001); e[191] = 1'b1; e[28] = 1'b1; e[13] = 1'b1;
    send(v, e, 1'b1, 1'b1, w);
    // Dense patterns exercising both folds, streamed back to back
    v = '1;
    send(v, ref_reduce(v), 1'b1, 1'b1, w);
    v = {1'b1, {96{4'ha}}};
    send(v, ref_reduce(v), 1'b1, 1'b1, w);
    v = {1'b0, {48{8'h3c}}};
    send(v, ref_reduce(v), 1'b1, 1'b1, w);
    drain();

    // Backpressure: result held, in_ready low, stray in_valid ignored
    v = '0; v[300] = 1'b1; v[5] = 1'b1;
    e = ref_reduce(v);
    send(v, e, 1'b0, 1'b0, w);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    held = out_c;
    chk("bp_first_out", held, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i < 4);
      in_prod  = '1;
      #1;
      chk("bp_out_valid", N'(out_valid), N'(1));
      chk("bp_out_c", out_c, held);
      chk("bp_in_ready", N'(in_ready), '0);
    end
    v = '0; v[250] = 1'b1;
    send(v, ref_reduce(v), 1'b1, 1'b1, w);
    chk("bp_same_cycle_accept", N'(w), '0);
    drain();

    // Reset pulsed while the product sits in S_FOLD2
    v = '0; v[193] = 1'b1;
    send(v, N'(16'h8001), 1'b1, 1'b1, w);
    @(posedge clk);
    #3;
    chk("pre_rst_busy", N'(busy), N'(1));
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("midrst_out_valid", N'(out_valid), '0);
    chk("midrst_out_c", out_c, '0);
    chk("midrst_busy", N'(busy), '0);
    chk("midrst_in_ready", N'(in_ready), N'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_valid", N'(out_valid), '0);
    end
    send(v, N'(16'h8001), 1'b1, 1'b1, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
